uart_tx_periph: RTL and testbench
=================================

Name: uart_tx_periph

Overview:
- Memory-mapped UART transmitter that acts as the responder on the core's data-memory port, the same port the RAM serves (we/sel/addr/wdata/rdata).
- The EX stage writes bytes into a TX FIFO.
- A serializer FSM shifts each byte out on txd as 8N1.
- The core reads status and the baud divider back through rdata.

Parameters:
- BASE_ADDR, 32'h1000_0000, base of the 16-byte register window; address bits [3:2] select the register.
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2, minimum 2.
- DEFAULT_DIV, 16'd433, reset value of BAUDDIV. Bit period is BAUDDIV+1 clk cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- we  in  1  write enable from EX
- sel  in  4  byte-lane enables (MenSelBus width)
- wraddr  in  32  read/write byte address (MemAddrBus)
- wdata  in  32  write data (MemBus)
- rdata  out  32  read data (MemBus); combinational
- txd  out  1  serial output; idles high; registered
- tx_irq  out  1  level interrupt = irq_en & fifo_empty & ~busy; registered

Behaviour:
- Address hit: wraddr[31:4] == BASE_ADDR[31:4]. Register offsets:
  - 0x0 TXDATA: write-only; reads return 0.
  - 0x4 STATUS: bit0 busy, bit1 full, bit2 empty, bit3 overflow (sticky), bits[11:8] fifo count; other bits read 0.
  - 0x8 BAUDDIV: bits[15:0] read/write.
  - 0xC CTRL: bit0 irq_en, read/write.
- Write to TXDATA: only when hit & we & sel[0]. Pushes wdata[7:0] at the clock edge.
  - Full at that edge: byte dropped, overflow set.
  - Full is evaluated on the pre-edge count. A push and a pop in the same cycle while full still drops the byte.
- Write to STATUS: writing 1 to wdata[3] with sel[0] clears overflow. Set has priority over clear in the same cycle.
- BAUDDIV is written per byte lane: sel[0] → [7:0], sel[1] → [15:8]. A new value takes effect at the next bit boundary. The in-flight bit finishes with its old count.
- CTRL is written only when sel[0] is asserted.
- Writes with no hit are ignored. Reads with no hit, or with we=1, return 32'h0.
- rdata is a combinational function of wraddr and current register state, so the core completes a load in one cycle.
- FIFO: circular buffer with read/write pointers and a count register of width clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- Serializer FSM:
  - IDLE: txd=1. If the FIFO is non-empty, pop into the shift register, load the baud counter with BAUDDIV, go to START.
  - START: txd=0 for BAUDDIV+1 cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0], LSB first. At the end of each bit period shift right and increment the index. After bit 7 go to STOP.
  - STOP: txd=1 for BAUDDIV+1 cycles. Then pop the next byte and go directly to START if the FIFO is non-empty (back-to-back frames, no idle gap); otherwise go to IDLE.
- busy = (state != IDLE).
- Latency: a TXDATA write at edge N, with the FIFO empty and the FSM in IDLE, pops at edge N+1. txd falls after edge N+2. A frame lasts 10*(BAUDDIV+1) cycles.
- Baud counter counts down to 0. The bit ends when counter==0 is sampled, and the counter reloads from BAUDDIV.
- Reset values, including reset asserted mid-frame (takes effect at the next edge):
  - state=IDLE, txd=1, tx_irq=0, FIFO flushed (count=0), pointers=0, overflow=0.
  - BAUDDIV=DEFAULT_DIV, irq_en=0, shift register=0.

Decomposition:
- Shared package/defines: register offsets, STATUS bit positions, FSM state encodings (IDLE/START/DATA/STOP, 2 bits), DEFAULT_DIV.
- Data-bus widths reuse the existing MemBus/MemAddrBus/MenSelBus defines.
- One natural sub-module: sync_fifo, parameterized on width and depth, with push/pop/full/empty/count.
- The register decode and the serializer FSM stay in uart_tx_periph.

Test Plan:
- Reset, then BAUDDIV=3; write 0xA5 to TXDATA → txd falls 2 cycles after the write edge. Bit sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. busy=1 for 40 cycles, then STATUS reads 0x104? No: reads empty=1, busy=0, i.e. 32'h4.
- BAUDDIV=0; 9 back-to-back writes 0x00..0x08 with FIFO_DEPTH=8 → first byte popped immediately, remaining 8 fill the FIFO, so STATUS shows full=1, count=8, overflow=0. A 10th write → overflow=1 and the byte is not transmitted. Frames appear on txd with no idle gap between stop and start.
- Write 0x8 to STATUS after overflow → bit3 clears. A same-cycle push-drop plus clear leaves overflow=1.
- CTRL.irq_en=1 with FIFO empty and idle → tx_irq=1. Write one byte → tx_irq=0 the next cycle, and returns to 1 after the stop bit ends.
- Assert rst mid-DATA bit 4 with 3 bytes queued → next edge txd=1, state IDLE, count=0, BAUDDIV reads DEFAULT_DIV, no further frames.
- Write TXDATA with sel=4'b0010, or an address outside the window → no push. Reads outside the window or at 0x0 return 32'h0. A BAUDDIV write with sel=4'b0010 updates only [15:8].

Source files
------------

// File: rtl/uart_tx_periph_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: bus widths, register map,
// STATUS bit positions and serializer state encoding.
package uart_tx_periph_pkg;

  localparam int unsigned MemBusW     = 32;
  localparam int unsigned MemAddrBusW = 32;
  localparam int unsigned MenSelBusW  = 4;

  localparam logic [15:0] DefaultDiv = 16'd433;

  // Register select, taken from address bits [3:2]
  typedef enum logic [1:0] {
    RegTxData  = 2'd0,
    RegStatus  = 2'd1,
    RegBaudDiv = 2'd2,
    RegCtrl    = 2'd3
  } reg_offset_e;

  localparam int unsigned StatusBusyBit  = 0;
  localparam int unsigned StatusFullBit  = 1;
  localparam int unsigned StatusEmptyBit = 2;
  localparam int unsigned StatusOvfBit   = 3;
  localparam int unsigned StatusCntLsb   = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_periph_sync_fifo.sv
// Synchronous circular-buffer FIFO; pushes while full and pops while empty are ignored,
// with fullness judged on the pre-edge count.
module uart_tx_periph_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [Width-1:0]         wdata,
  output logic [Width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem_q[rptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      // Depth is a power of two, so pointers wrap naturally
      if (push_ok) wptr_q <= wptr_q + PtrW'(1);
      if (pop_ok)  rptr_q <= rptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset: the pointers and count define validity
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter on the data-memory port: register decode,
// TX FIFO and serializer FSM.
module uart_tx_periph
  import uart_tx_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = DefaultDiv
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [MenSelBusW-1:0]  sel,
  input  logic [MemAddrBusW-1:0] wraddr,
  input  logic [MemBusW-1:0]     wdata,
  output logic [MemBusW-1:0]     rdata,
  output logic                   txd,
  output logic                   tx_irq
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic        hit;
  reg_offset_e reg_off;
  logic        wr_txdata, wr_status, wr_baud, wr_ctrl;

  logic [15:0] baud_q;
  logic        irq_en_q;
  logic        overflow_q;

  logic            fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_rdata;
  logic [CntW-1:0] fifo_count;
  logic [3:0]      count4;

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_idx_q;
  logic        bit_end, busy;
  logic        txd_q, txd_d, tx_irq_q;

  logic unused_bits;
  assign unused_bits = ^{sel[3:2], wraddr[1:0], wdata[31:16]};

  assign hit       = (wraddr[31:4] == BASE_ADDR[31:4]);
  assign reg_off   = reg_offset_e'(wraddr[3:2]);
  assign wr_txdata = hit & we & sel[0] & (reg_off == RegTxData);
  assign wr_status = hit & we & sel[0] & (reg_off == RegStatus);
  assign wr_baud   = hit & we & (reg_off == RegBaudDiv);
  assign wr_ctrl   = hit & we & sel[0] & (reg_off == RegCtrl);

  uart_tx_periph_sync_fifo #(
    .Width (8),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_txdata),
    .pop   (fifo_pop),
    .wdata (wdata[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_q     <= DEFAULT_DIV;
      irq_en_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_baud & sel[0]) baud_q[7:0]  <= wdata[7:0];
      if (wr_baud & sel[1]) baud_q[15:8] <= wdata[15:8];
      if (wr_ctrl)          irq_en_q     <= wdata[0];
      // A dropped push wins over a clear in the same cycle
      if (wr_txdata & fifo_full)          overflow_q <= 1'b1;
      else if (wr_status & wdata[StatusOvfBit]) overflow_q <= 1'b0;
    end
  end

  assign count4 = 4'(fifo_count);

  always_comb begin
    rdata = '0;
    if (hit && !we) begin
      case (reg_off)
        RegStatus: begin
          rdata[StatusBusyBit]       = busy;
          rdata[StatusFullBit]       = fifo_full;
          rdata[StatusEmptyBit]      = fifo_empty;
          rdata[StatusOvfBit]        = overflow_q;
          rdata[StatusCntLsb +: 4]   = count4;
        end
        RegBaudDiv: rdata[15:0] = baud_q;
        RegCtrl:    rdata[0]    = irq_en_q;
        default:    rdata       = '0;
      endcase
    end
  end

  assign busy    = (state_q != StIdle);
  assign bit_end = (cnt_q == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (!fifo_empty) state_d = StStart;
      StStart: if (bit_end) state_d = StData;
      StData:  if (bit_end && bit_idx_q == 3'd7) state_d = StStop;
      StStop:  if (bit_end) state_d = fifo_empty ? StIdle : StStart;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fifo_pop = 1'b0;
    txd_d    = 1'b1;
    case (state_q)
      StIdle:  fifo_pop = !fifo_empty;
      StStart: txd_d    = 1'b0;
      StData:  txd_d    = shift_q[0];
      StStop:  fifo_pop = bit_end & !fifo_empty;
      default: txd_d    = 1'b1;
    endcase
  end

  // Bit timing reloads from the live divider, so divider writes apply at the next bit
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      shift_q   <= '0;
      bit_idx_q <= '0;
      txd_q     <= 1'b1;
      tx_irq_q  <= 1'b0;
    end else begin
      txd_q    <= txd_d;
      tx_irq_q <= irq_en_q & fifo_empty & ~busy;
      if (fifo_pop) begin
        shift_q   <= fifo_rdata;
        cnt_q     <= baud_q;
        bit_idx_q <= '0;
      end else if (busy) begin
        if (bit_end) begin
          cnt_q <= baud_q;
          if (state_q == StData) begin
            shift_q   <= shift_q >> 1;
            bit_idx_q <= bit_idx_q + 3'd1;
          end
        end else begin
          cnt_q <= cnt_q - 16'd1;
        end
      end
    end
  end

  assign txd    = txd_q;
  assign tx_irq = tx_irq_q;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph: register vector table plus hand-timed frame,
// burst/overflow, interrupt and mid-frame reset sequences.
module tb_uart_tx_periph;

  localparam logic [31:0] ATx     = 32'h1000_0000;
  localparam logic [31:0] AStatus = 32'h1000_0004;
  localparam logic [31:0] ABaud   = 32'h1000_0008;
  localparam logic [31:0] ACtrl   = 32'h1000_000C;

  logic        clk, rst, we;
  logic [3:0]  sel;
  logic [31:0] wraddr, wdata, rdata;
  logic        txd, tx_irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  uart_tx_periph dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .sel    (sel),
    .wraddr (wraddr),
    .wdata  (wdata),
    .rdata  (rdata),
    .txd    (txd),
    .tx_irq (tx_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    wraddr = a;
    we     = 1'b0;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    wraddr = a;
    sel    = s;
    wdata  = d;
    we     = 1'b1;
    @(posedge clk);
    #1;
    we  = 1'b0;
    sel = 4'b0000;
  endtask

  // 8N1 frame: bit 0 start, 1..8 data LSB first, 9 stop
  function automatic logic frame_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  initial begin
    vecs[0] = '{1'b1, ABaud,          4'b1111, 32'h0000_1234, ABaud,          32'h0000_1234};
    vecs[1] = '{1'b1, ABaud,          4'b0010, 32'h0000_AB99, ABaud,          32'h0000_AB34};
    vecs[2] = '{1'b1, ABaud,          4'b0001, 32'hFFFF_FF03, ABaud,          32'h0000_AB03};
    vecs[3] = '{1'b1, ABaud,          4'b0011, 32'h0000_0003, ABaud,          32'h0000_0003};
    vecs[4] = '{1'b0, ATx,            4'b0000, 32'h0,         ATx,            32'h0};
    vecs[5] = '{1'b1, ATx,            4'b0010, 32'h0000_0055, AStatus,        32'h0000_0004};
    vecs[6] = '{1'b1, 32'h1000_0010,  4'b1111, 32'h0000_0066, AStatus,        32'h0000_0004};
    vecs[7] = '{1'b0, 32'h2000_0008,  4'b0000, 32'h0,         32'h2000_0008,  32'h0};
    vecs[8] = '{1'b1, ACtrl,          4'b0010, 32'h0000_0001, ACtrl,          32'h0};
    vecs[9] = '{1'b1, 32'h1000_0018,  4'b1111, 32'h0000_0007, ABaud,          32'h0000_0003};

    rst = 1'b1; we = 1'b0; sel = 4'b0000; wraddr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_txd", 32'(txd), 32'd1);
    check("reset_irq", 32'(tx_irq), 32'd0);
    check_read("reset_status", AStatus, 32'h4);
    check_read("reset_baud", ABaud, 32'd433);
    check_read("reset_ctrl", ACtrl, 32'h0);
    rst = 1'b0;

    // rdata must be zero while the bus is writing
    wraddr = AStatus; sel = 4'b0000; we = 1'b1;
    #1;
    check("rdata_during_write", rdata, 32'h0);
    we = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].sel, vecs[i].wdata);
      check_read($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
    end

    // Single frame, BAUDDIV=3
    bus_write(ATx, 4'b0001, 32'hA5);
    check_read("status_after_push", AStatus, 32'h100);
    check("frame_txd_j0", 32'(txd), 32'd1);
    for (int j = 1; j <= 44; j++) begin
      @(posedge clk);
      #1;
      check($sformatf("frame_txd_j%0d", j), 32'(txd),
            (j >= 2 && j < 42) ? 32'(frame_bit(8'hA5, (j - 2) / 4)) : 32'd1);
      check($sformatf("frame_busy_j%0d", j), 32'(rdata[0]), (j <= 40) ? 32'd1 : 32'd0);
    end
    check_read("status_after_frame", AStatus, 32'h4);

    // Burst of ten bytes at BAUDDIV=0; the tenth overflows
    bus_write(ABaud, 4'b0011, 32'h0);
    for (int j = 0; j <= 105; j++) begin
      if (j <= 9) begin
        wraddr = ATx; sel = 4'b0001; wdata = 32'(j); we = 1'b1;
      end
      @(posedge clk);
      #1;
      we = 1'b0; sel = 4'b0000;
      if (j == 8) check_read("burst_full", AStatus, 32'h803);
      if (j == 9) check_read("burst_overflow", AStatus, 32'h80B);
      check($sformatf("burst_txd_j%0d", j), 32'(txd),
            (j >= 2 && (j - 2) / 10 < 9) ? 32'(frame_bit(8'((j - 2) / 10), (j - 2) % 10))
                                         : 32'd1);
    end
    check_read("drained_ovf_sticky", AStatus, 32'hC);
    bus_write(AStatus, 4'b0010, 32'h8);
    check_read("ovf_clear_needs_sel0", AStatus, 32'hC);
    bus_write(AStatus, 4'b0001, 32'h8);
    check_read("ovf_cleared", AStatus, 32'h4);

    // Interrupt
    bus_write(ACtrl, 4'b0001, 32'h1);
    check("irq_lag", 32'(tx_irq), 32'd0);
    @(posedge clk);
    #1;
    check("irq_on", 32'(tx_irq), 32'd1);
    bus_write(ATx, 4'b0001, 32'h3C);
    check("irq_push_edge", 32'(tx_irq), 32'd1);
    for (int j = 1; j <= 14; j++) begin
      @(posedge clk);
      #1;
      check($sformatf("irq_j%0d", j), 32'(tx_irq), (j >= 12) ? 32'd1 : 32'd0);
    end

    // Reset in the middle of data bit 4 with three bytes queued
    bus_write(ABaud, 4'b0011, 32'h3);
    bus_write(ATx, 4'b0001, 32'h00);
    bus_write(ATx, 4'b0001, 32'h11);
    bus_write(ATx, 4'b0001, 32'h22);
    bus_write(ATx, 4'b0001, 32'h33);
    repeat (19) @(posedge clk);
    #1;
    check("pre_reset_bit4", 32'(txd), 32'd0);
    check_read("pre_reset_status", AStatus, 32'h301);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_reset_txd", 32'(txd), 32'd1);
    check("mid_reset_irq", 32'(tx_irq), 32'd0);
    check_read("mid_reset_status", AStatus, 32'h4);
    check_read("mid_reset_baud", ABaud, 32'd433);
    check_read("mid_reset_ctrl", ACtrl, 32'h0);
    rst = 1'b0;
    for (int j = 0; j < 60; j++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_reset_txd_j%0d", j), 32'(txd), 32'd1);
    end
    check_read("post_reset_status", AStatus, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
